// File: rtl/pixel_fetcher_if.sv
// Bundle of the coordinate, RAM and pixel-stream signals around pixel_fetcher.
// The fetcher uses the slave view; the sweeper, RAM and consumer side uses master.
interface pixel_fetcher_if #(
    parameter int W_X    = 6,
    parameter int W_Y    = 6,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              addr_valid;
    logic              addr_ready;
    logic [W_X-1:0]    x;
    logic [W_Y-1:0]    y;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              pix_last;
    logic              oob_err;

    modport master (
        output addr_valid, x, y, mem_rd_data, pix_ready,
        input  addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last, oob_err
    );

    modport slave (
        input  addr_valid, x, y, mem_rd_data, pix_ready,
        output addr_ready, mem_rd_en, mem_addr, pix_valid, pix_data, pix_last, oob_err
    );
endinterface

// File: rtl/pixel_fetcher.sv
// Pixel fetcher: turns an (x,y) coordinate stream into an in-order pixel stream.
// Each accepted coordinate issues one RAM read; the returning word lands in a small
// FIFO. Coordinates are only accepted while FIFO entries plus the read in flight
// leave room, so back-pressure on the pixel side can never drop a returned word.
module pixel_fetcher #(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int SWEEP_X    = 25,
    parameter int SWEEP_Y    = 25,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 3
) (
    input logic           clk,
    input logic           rst,
    pixel_fetcher_if.slave bus
);
    localparam int W_X    = $clog2(IMG_WIDTH);
    localparam int W_Y    = $clog2(IMG_HEIGHT);
    localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int W_PIX  = $clog2(SWEEP_X * SWEEP_Y);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    // Wide enough for a full FIFO plus one read in flight.
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 2);

    localparam logic [W_X-1:0]    X_MAX      = W_X'(IMG_WIDTH - 1);
    localparam logic [W_Y-1:0]    Y_MAX      = W_Y'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_WIDTH);
    localparam logic [W_PIX-1:0]  LAST_CNT   = W_PIX'(SWEEP_X * SWEEP_Y - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  fill_reg;
    logic [CNT_W-1:0]  fill_next;
    logic [CNT_W-1:0]  pending_next;
    logic              inflight_reg;
    logic              addr_ready_reg;
    logic              oob_reg;
    logic [W_PIX-1:0]  pix_cnt_reg;

    logic              accept;
    logic              push;
    logic              pop;
    logic              pix_valid_int;
    logic              at_last;
    logic              x_over;
    logic              y_over;
    logic [W_X-1:0]    xc;
    logic [W_Y-1:0]    yc;
    logic [ADDR_W-1:0] addr_calc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshakes: the accept side looks only at registered state.
    assign accept        = bus.addr_valid & addr_ready_reg;
    assign push          = inflight_reg;
    assign pix_valid_int = (fill_reg != '0);
    assign pop           = pix_valid_int & bus.pix_ready;
    assign at_last       = (pix_cnt_reg == LAST_CNT);

    // Coordinate clamping and address generation at full address width.
    assign x_over    = (bus.x > X_MAX);
    assign y_over    = (bus.y > Y_MAX);
    assign xc        = x_over ? X_MAX : bus.x;
    assign yc        = y_over ? Y_MAX : bus.y;
    assign addr_calc = ADDR_W'(yc) * ROW_STRIDE + ADDR_W'(xc);

    assign bus.mem_rd_en  = accept;
    assign bus.mem_addr   = accept ? addr_calc : '0;
    assign bus.addr_ready = addr_ready_reg;
    assign bus.pix_valid  = pix_valid_int;
    assign bus.pix_data   = pix_valid_int ? fifo_mem[rd_ptr_reg] : '0;
    assign bus.pix_last   = pix_valid_int & at_last;
    assign bus.oob_err    = oob_reg;

    // Next occupancy and the room check that decides next cycle's addr_ready.
    always_comb begin
        fill_next = fill_reg;
        if (push && !pop) begin
            fill_next = fill_reg + CNT_W'(1);
        end else if (!push && pop) begin
            fill_next = fill_reg - CNT_W'(1);
        end
        pending_next = fill_next + CNT_W'(accept);
    end

    // Control state: FIFO pointers, in-flight flag, window counter, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            fill_reg       <= '0;
            inflight_reg   <= 1'b0;
            addr_ready_reg <= 1'b0;
            oob_reg        <= 1'b0;
            pix_cnt_reg    <= '0;
        end else begin
            fill_reg       <= fill_next;
            inflight_reg   <= accept;
            addr_ready_reg <= (pending_next < DEPTH_C);
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg  <= ptr_inc(rd_ptr_reg);
                pix_cnt_reg <= at_last ? '0 : pix_cnt_reg + W_PIX'(1);
            end
            if (accept && (x_over || y_over)) begin
                oob_reg <= 1'b1;
            end
        end
    end

    // FIFO storage: returned RAM word goes to the tail the cycle after the read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= bus.mem_rd_data;
        end
    end
endmodule

// File: tb/tb_pixel_fetcher.sv
// Self-checking bench for pixel_fetcher: random coordinate streams are compared
// against an arithmetic reference (clamp, y*W+x, low byte, window position).
module tb_pixel_fetcher;
    localparam int IMG_WIDTH  = 41;
    localparam int IMG_HEIGHT = 50;
    localparam int SWEEP_X    = 25;
    localparam int SWEEP_Y    = 25;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 3;
    localparam int W_X        = $clog2(IMG_WIDTH);
    localparam int W_Y        = $clog2(IMG_HEIGHT);
    localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int WIN        = SWEEP_X * SWEEP_Y;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pixel_fetcher_if #(.W_X(W_X), .W_Y(W_Y), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pixel_fetcher #(
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .SWEEP_X(SWEEP_X),
        .SWEEP_Y(SWEEP_Y), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;          // 0 always ready, 1 random, 2 never, 3 stall window
    int stall_start = 1 << 30;

    logic [W_X-1:0] xq[$];
    logic [W_Y-1:0] yq[$];
    int acc_cycle[$];
    int acc_addr[$];
    int pop_data[$];
    bit pop_last[$];
    int pop_cycle[$];

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word at address a holds a[7:0], one cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    end

    // Consumer ready pattern.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.pix_ready = 1'b1;
                1: bus.pix_ready = ($urandom_range(0, 3) != 0);
                2: bus.pix_ready = 1'b0;
                default: bus.pix_ready = !(cyc >= stall_start && cyc < stall_start + 10);
            endcase
        end
    end

    // Recorder of accepted reads and popped pixels (no checking here).
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_en) begin
                acc_cycle.push_back(cyc);
                acc_addr.push_back(int'(bus.mem_addr));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                pop_data.push_back(int'(bus.pix_data));
                pop_last.push_back(bus.pix_last);
                pop_cycle.push_back(cyc);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // Reference: clamp each coordinate, then row-major address.
    function automatic int model_addr(input int x, input int y);
        int xc;
        int yc;
        xc = (x > IMG_WIDTH - 1) ? IMG_WIDTH - 1 : x;
        yc = (y > IMG_HEIGHT - 1) ? IMG_HEIGHT - 1 : y;
        return yc * IMG_WIDTH + xc;
    endfunction

    // Pop number g (0-based since reset) ends a window every WIN pixels.
    function automatic bit model_last(input int g);
        return ((g + 1) % WIN) == 0;
    endfunction

    task automatic clear_queues();
        acc_cycle.delete();
        acc_addr.delete();
        pop_data.delete();
        pop_last.delete();
        pop_cycle.delete();
    endtask

    task automatic do_reset();
        bus.addr_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic fill_random(input int n);
        xq.delete();
        yq.delete();
        for (int i = 0; i < n; i++) begin
            xq.push_back(W_X'($urandom_range(0, IMG_WIDTH - 1)));
            yq.push_back(W_Y'($urandom_range(0, IMG_HEIGHT - 1)));
        end
    endtask

    // Drives every coordinate in xq/yq, holding each until accepted.
    task automatic send_all(input int gap_pct, input int budget);
        int i;
        int spent;
        bit go;
        i = 0;
        spent = 0;
        @(posedge clk);
        #1;
        while (i < xq.size() && spent < budget) begin
            go = (int'($urandom_range(0, 99)) >= gap_pct);
            bus.addr_valid = go;
            bus.x = xq[i];
            bus.y = yq[i];
            @(negedge clk);
            go = go && bus.addr_ready;
            @(posedge clk);
            #1;
            if (go) i++;
            spent++;
        end
        bus.addr_valid = 1'b0;
        n_checks++;
        if (i != xq.size()) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %0d coords, required %0d", i, xq.size());
        end
    endtask

    task automatic wait_pops(input int target, input int budget, output bit ok);
        int k;
        k = 0;
        while (pop_data.size() < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
        ok = (pop_data.size() == target);
    endtask

    task automatic test_reset();
        logic [ADDR_W+DATA_W+4:0] outs;
        @(negedge clk);
        outs = {bus.addr_ready, bus.mem_rd_en, bus.mem_addr, bus.pix_valid,
                bus.pix_data, bus.pix_last, bus.oob_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.addr_ready !== 1'b1 || bus.pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: addr_ready=%b pix_valid=%b required 1 0",
                     bus.addr_ready, bus.pix_valid);
        end
        clear_queues();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bit ok;
        xq.delete(); yq.delete();
        xq.push_back(W_X'(3));
        yq.push_back(W_Y'(2));
        rdy_mode = 0;
        send_all(0, 20);
        wait_pops(1, 20, ok);
        n_checks++;
        if (!ok || acc_addr.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: pops=%0d reads=%0d required 1 1",
                     pop_data.size(), acc_addr.size());
        end else begin
            n_checks += 4;
            if (acc_addr[0] !== 85) begin
                n_fail++;
                $display("FAIL single_addr: got %0d required 85", acc_addr[0]);
            end
            if (pop_data[0] !== 85) begin
                n_fail++;
                $display("FAIL single_data: got %0d required 85", pop_data[0]);
            end
            if (pop_cycle[0] - acc_cycle[0] !== 2) begin
                n_fail++;
                $display("FAIL single_latency: got %0d required 2", pop_cycle[0] - acc_cycle[0]);
            end
            if (pop_last[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_last: got %b required 0", pop_last[0]);
            end
        end
        $display("test_single: addr=85 data=85");
    endtask

    task automatic test_stream();
        int pb;
        int ab;
        bit ok;
        pb = pop_data.size();
        ab = acc_addr.size();
        fill_random(100);
        rdy_mode = 0;
        send_all(0, 400);
        wait_pops(pb + 100, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stream_count: pops=%0d required %0d", pop_data.size() - pb, 100);
        end else begin
            n_checks += 2;
            if (acc_cycle[ab + 99] - acc_cycle[ab] !== 99) begin
                n_fail++;
                $display("FAIL stream_accept_span: got %0d required 99",
                         acc_cycle[ab + 99] - acc_cycle[ab]);
            end
            if (pop_cycle[pb + 99] - acc_cycle[ab] !== 101) begin
                n_fail++;
                $display("FAIL stream_total_span: got %0d required 101",
                         pop_cycle[pb + 99] - acc_cycle[ab]);
            end
            for (int k = 0; k < 100; k++) begin
                n_checks += 2;
                if (acc_addr[ab + k] !== model_addr(int'(xq[k]), int'(yq[k]))) begin
                    n_fail++;
                    $display("FAIL stream_addr[%0d]: got %0d required %0d", k,
                             acc_addr[ab + k], model_addr(int'(xq[k]), int'(yq[k])));
                end
                if (pop_data[pb + k] !== model_addr(int'(xq[k]), int'(yq[k])) % 256 ||
                    pop_last[pb + k] !== model_last(pb + k)) begin
                    n_fail++;
                    $display("FAIL stream_pix[%0d]: got %0d/%b required %0d/%b", k,
                             pop_data[pb + k], pop_last[pb + k],
                             model_addr(int'(xq[k]), int'(yq[k])) % 256, model_last(pb + k));
                end
            end
        end
        $display("test_stream: 100 coords streamed");
    endtask

    task automatic test_backpressure();
        int pb;
        int stalled_acc;
        bit ok;
        pb = pop_data.size();
        fill_random(40);
        stall_start = cyc + 12;
        rdy_mode = 3;
        fork
            send_all(0, 400);
            begin
                int held;
                while (cyc < stall_start) @(negedge clk);
                held = int'(bus.pix_data);
                n_checks++;
                if (bus.pix_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_valid_at_stall: got %b required 1", bus.pix_valid);
                end
                repeat (9) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus.pix_valid !== 1'b1 || int'(bus.pix_data) !== held) begin
                        n_fail++;
                        $display("FAIL bp_stable: valid=%b data=%0d required 1 %0d",
                                 bus.pix_valid, bus.pix_data, held);
                    end
                end
                n_checks++;
                if (bus.addr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_addr_ready: got %b required 0", bus.addr_ready);
                end
            end
        join
        wait_pops(pb + 40, 400, ok);
        stalled_acc = 0;
        foreach (acc_cycle[i]) begin
            if (acc_cycle[i] >= stall_start && acc_cycle[i] < stall_start + 10) stalled_acc++;
        end
        n_checks++;
        if (stalled_acc > 3) begin
            n_fail++;
            $display("FAIL bp_stall_accepts: got %0d required <=3", stalled_acc);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_count: pops=%0d required 40", pop_data.size() - pb);
        end else begin
            for (int k = 0; k < 40; k++) begin
                n_checks++;
                if (pop_data[pb + k] !== model_addr(int'(xq[k]), int'(yq[k])) % 256 ||
                    pop_last[pb + k] !== model_last(pb + k)) begin
                    n_fail++;
                    $display("FAIL bp_pix[%0d]: got %0d/%b required %0d/%b", k,
                             pop_data[pb + k], pop_last[pb + k],
                             model_addr(int'(xq[k]), int'(yq[k])) % 256, model_last(pb + k));
                end
            end
        end
        stall_start = 1 << 30;
        rdy_mode = 0;
        $display("test_backpressure: %0d accepts during stall", stalled_acc);
    endtask

    task automatic test_window();
        bit ok;
        int lasts;
        do_reset();
        fill_random(2 * WIN);
        rdy_mode = 1;
        send_all(20, 8000);
        wait_pops(2 * WIN, 2000, ok);
        rdy_mode = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL window_count: pops=%0d required %0d", pop_data.size(), 2 * WIN);
        end else begin
            lasts = 0;
            for (int k = 0; k < 2 * WIN; k++) begin
                n_checks++;
                if (pop_last[k]) lasts++;
                if (pop_data[k] !== model_addr(int'(xq[k]), int'(yq[k])) % 256 ||
                    pop_last[k] !== model_last(k)) begin
                    n_fail++;
                    $display("FAIL window_pix[%0d]: got %0d/%b required %0d/%b", k,
                             pop_data[k], pop_last[k],
                             model_addr(int'(xq[k]), int'(yq[k])) % 256, model_last(k));
                end
            end
            n_checks++;
            if (lasts !== 2 || pop_last[WIN - 1] !== 1'b1 || pop_last[2 * WIN - 1] !== 1'b1) begin
                n_fail++;
                $display("FAIL window_last_total: got %0d required 2 at pops %0d and %0d",
                         lasts, WIN, 2 * WIN);
            end
        end
        $display("test_window: %0d pixels over two windows", pop_data.size());
    endtask

    task automatic test_oob();
        int cx[3] = '{41, 40, 45};
        int cy[3] = '{0, 49, 60};
        int ea[3] = '{40, 2049, 2049};
        bit eo[3] = '{1'b1, 1'b0, 1'b1};
        bit ok;
        rdy_mode = 0;
        for (int c = 0; c < 3; c++) begin
            do_reset();
            n_checks++;
            if (bus.oob_err !== 1'b0) begin
                n_fail++;
                $display("FAIL oob_clear[%0d]: got %b required 0", c, bus.oob_err);
            end
            xq.delete(); yq.delete();
            xq.push_back(W_X'(cx[c]));
            yq.push_back(W_Y'(cy[c]));
            send_all(0, 20);
            wait_pops(1, 20, ok);
            n_checks++;
            if (!ok || acc_addr.size() != 1 || acc_addr[0] !== ea[c] ||
                pop_data[0] !== ea[c] % 256 || bus.oob_err !== eo[c]) begin
                n_fail++;
                $display("FAIL oob_case[%0d]: addr=%0d data=%0d oob=%b required %0d %0d %b",
                         c, acc_addr.size() > 0 ? acc_addr[0] : -1,
                         pop_data.size() > 0 ? pop_data[0] : -1, bus.oob_err,
                         ea[c], ea[c] % 256, eo[c]);
            end
        end
        fill_random(50);
        send_all(0, 200);
        wait_pops(51, 200, ok);
        n_checks++;
        if (!ok || bus.oob_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_sticky: pops=%0d oob=%b required 51 1", pop_data.size(), bus.oob_err);
        end
        $display("test_oob: clamped address 2049, oob_err=%b", bus.oob_err);
    endtask

    task automatic test_reset_midop();
        logic [ADDR_W+DATA_W+4:0] outs;
        bit ok;
        rdy_mode = 2;
        do_reset();
        fill_random(3);
        send_all(0, 30);
        n_checks++;
        if (bus.pix_valid !== 1'b1 || acc_addr.size() != 3) begin
            n_fail++;
            $display("FAIL midop_prefill: valid=%b reads=%0d required 1 3",
                     bus.pix_valid, acc_addr.size());
        end
        rst = 1'b1;
        #1;
        outs = {bus.addr_ready, bus.mem_rd_en, bus.mem_addr, bus.pix_valid,
                bus.pix_data, bus.pix_last, bus.oob_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midop_async_reset: got %h required 0", outs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_queues();
        rdy_mode = 0;
        fill_random(1);
        send_all(0, 20);
        wait_pops(1, 20, ok);
        n_checks++;
        if (!ok || pop_data[0] !== model_addr(int'(xq[0]), int'(yq[0])) % 256 ||
            pop_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_restart: pops=%0d data=%0d required 1 %0d", pop_data.size(),
                     pop_data.size() > 0 ? pop_data[0] : -1,
                     model_addr(int'(xq[0]), int'(yq[0])) % 256);
        end
        $display("test_reset_midop: restart pixel checked");
    endtask

    initial begin
        bus.addr_valid = 1'b0;
        bus.x = '0;
        bus.y = '0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_window();
        test_oob();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
